ifetch_responder: RTL and testbench

//  Fetch-side responder for the IFU instruction port: serves inst_addr (physical PC, held by the
//  IFU until if_rdata_valid) with one 32-bit instruction word per request. Halfword-aligned PCs
//  (RVC) are supported; a 32-bit instruction straddling a word boundary is assembled from two bus

---
 rtl/ifetch_responder_pkg.sv | 48 ++++
 rtl/ifetch_responder_if.sv | 50 +++++
 rtl/ifetch_responder_ifr_word_buf.sv | 50 +++++
 rtl/ifetch_responder.sv | 215 +++++++++++++++++++++
 tb/tb_ifetch_responder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_responder_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_responder_pkg
// Shared definitions for the instruction-fetch responder:
//   - ifr_state_t        : responder FSM state encodings (IFR_ST_*)
//   - AXI_RESP_OKAY      : AXI-lite read response value meaning "no error"
//   - RVC_LOW_MASK       : low opcode bits that mark a full 32-bit instruction
//   - ifr_is_full_width  : true when a halfword starts a 32-bit instruction
//   - ifr_format         : builds the IFU-facing instruction word
// ----------------------------------------------------------------------------
package ifetch_responder_pkg;

  typedef enum logic [2:0] {
    IFR_ST_IDLE  = 3'd0,
    IFR_ST_REQ0  = 3'd1,
    IFR_ST_WAIT0 = 3'd2,
    IFR_ST_REQ1  = 3'd3,
    IFR_ST_WAIT1 = 3'd4,
    IFR_ST_RESP  = 3'd5,
    IFR_ST_DRAIN = 3'd6
  } ifr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] RVC_LOW_MASK  = 2'b11;

  // A halfword whose two low bits are both set is the first half of a
  // 32-bit instruction; anything else is a complete compressed instruction.
  function automatic logic ifr_is_full_width(input logic [15:0] half);
    ifr_is_full_width = ((half[1:0] & RVC_LOW_MASK) == RVC_LOW_MASK);
  endfunction

  // Select the instruction bits handed to the IFU:
  //   word-aligned PC            -> the whole word
  //   halfword PC, compressed    -> upper half, zero-extended
  //   halfword PC, straddling    -> low half of the next word on top
  function automatic logic [31:0] ifr_format(input logic        upper,
                                             input logic        straddle,
                                             input logic [31:0] w0,
                                             input logic [15:0] w1lo);
    logic [31:0] result;
    result = w0;
    if (upper) begin
      if (straddle) result = {w1lo, w0[31:16]};
      else          result = {16'h0000, w0[31:16]};
    end
    ifr_format = result;
  endfunction

endpackage

// File: rtl/ifetch_responder_if.sv
// ----------------------------------------------------------------------------
// ifetch_responder_if
// Bundles the two buses seen by the fetch responder: the IFU instruction port
// (request/flush/fence in, instruction/fault out) and the AXI4-lite read
// channel towards memory (AR and R channels).
//   modport master : the responder itself (AXI-lite initiator, IFU server)
//   modport slave  : the environment (IFU plus memory)
// Signal names keep the _i/_o suffixes as seen from the responder.
// ----------------------------------------------------------------------------
interface ifetch_responder_if #(
  parameter int ADDR_W = 32
);

  // IFU side
  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              flush_i;
  logic              fence_i_i;
  logic              rdata_valid_o;
  logic [31:0]       rdata_o;
  logic              fault_o;

  // AXI4-lite read side
  logic              ar_valid_o;
  logic              ar_ready_i;
  logic [ADDR_W-1:0] ar_addr_o;
  logic              r_valid_i;
  logic              r_ready_o;
  logic [31:0]       r_data_i;
  logic [1:0]        r_resp_i;

  modport master (
    input  fetch_req_i, fetch_addr_i, flush_i, fence_i_i,
    output rdata_valid_o, rdata_o, fault_o,
    output ar_valid_o, ar_addr_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i,
    output r_ready_o
  );

  modport slave (
    output fetch_req_i, fetch_addr_i, flush_i, fence_i_i,
    input  rdata_valid_o, rdata_o, fault_o,
    input  ar_valid_o, ar_addr_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i,
    input  r_ready_o
  );

endinterface

// File: rtl/ifetch_responder_ifr_word_buf.sv
// ----------------------------------------------------------------------------
// ifr_word_buf
// One-word instruction reuse buffer: a tag (word address), the word's data and
// a valid bit.
//   clk, rst         clock, asynchronous active-high reset (clears valid)
//   i_lookup_tag     word address being looked up
//   o_hit, o_data    lookup result (combinational) and stored word
//   i_install        write i_install_tag / i_install_data into the buffer
//   i_invalidate     drop the contents; wins over a same-cycle install
// With EN = 0 the buffer never hits and never installs.
// ----------------------------------------------------------------------------
module ifr_word_buf #(
  parameter int TAG_W = 30,
  parameter bit EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_hit,
  output logic [31:0]      o_data,
  input  logic             i_install,
  input  logic [TAG_W-1:0] i_install_tag,
  input  logic [31:0]      i_install_data,
  input  logic             i_invalidate
);

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;

  // Buffer storage. Invalidation has priority so that a beat arriving in the
  // same cycle as a fence can never survive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_invalidate) begin
      r_valid <= 1'b0;
    end else if (i_install && EN) begin
      r_valid <= 1'b1;
      r_tag   <= i_install_tag;
      r_data  <= i_install_data;
    end
  end

  assign o_hit  = EN && r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule

// File: rtl/ifetch_responder.sv
// ----------------------------------------------------------------------------
// ifetch_responder
// Fetch-side responder between the IFU instruction port and an AXI4-lite read
// port. Serves one 32-bit instruction word per request; halfword-aligned PCs
// are supported and a 32-bit instruction crossing a word boundary is built
// from two bus reads. A one-word buffer lets back-to-back fetches from the
// same word skip the bus.
//   clk, rst   clock, asynchronous active-high reset
//   bus        ifetch_responder_if.master (IFU port + AXI-lite AR/R channels)
// Parameters: ADDR_W address width, BUF_EN enables the reuse buffer.
// ----------------------------------------------------------------------------
module ifetch_responder
  import ifetch_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit BUF_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  ifetch_responder_if.master bus
);

  localparam int                TAG_W     = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  ifr_state_t r_state;
  ifr_state_t w_next;

  logic [ADDR_W-1:1] r_pc;
  logic [31:0]       r_w0;
  logic [15:0]       r_w1lo;
  logic              r_fault;
  logic              r_flushed;

  logic [ADDR_W-1:0] w_cur_w0;
  logic [ADDR_W-1:0] w_cur_w1;
  logic              w_buf_hit;
  logic [31:0]       w_buf_data;
  logic              w_hit_needs_w1;
  logic              w_straddle;
  logic              w_accept;
  logic              w_cap_hit;
  logic              w_cap_w0;
  logic              w_cap_w1;
  logic              w_set_fault;
  logic              w_mark_flush;
  logic              w_install;
  logic [TAG_W-1:0]  w_install_tag;
  logic              w_unused_ok;

  // Word addresses of the latched PC; the second word wraps naturally
  // modulo 2^ADDR_W.
  assign w_cur_w0 = {r_pc[ADDR_W-1:2], 2'b00};
  assign w_cur_w1 = w_cur_w0 + WORD_STEP;

  // On a buffer hit in IDLE the buffered word decides whether a halfword PC
  // straddles into the next word.
  assign w_hit_needs_w1 = bus.fetch_addr_i[1] && ifr_is_full_width(w_buf_data[31:16]);

  // Straddle decision for the response, made from the captured first word.
  assign w_straddle = r_pc[1] && ifr_is_full_width(r_w0[31:16]);

  // PC bit 0 is always zero for instruction addresses.
  assign w_unused_ok = bus.fetch_addr_i[0];

  ifr_word_buf #(
    .TAG_W (TAG_W),
    .EN    (BUF_EN)
  ) u_word_buf (
    .clk            (clk),
    .rst            (rst),
    .i_lookup_tag   (bus.fetch_addr_i[ADDR_W-1:2]),
    .o_hit          (w_buf_hit),
    .o_data         (w_buf_data),
    .i_install      (w_install),
    .i_install_tag  (w_install_tag),
    .i_install_data (bus.r_data_i),
    .i_invalidate   (bus.fence_i_i)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IFR_ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode. Every bus output is a function of the
  // current state, so nothing is driven outside the states that own it.
  // A flush seen in REQx is remembered in r_flushed because the address
  // phase must still complete before the outstanding beat can be drained.
  always_comb begin
    w_next            = r_state;
    bus.rdata_valid_o = 1'b0;
    bus.rdata_o       = '0;
    bus.fault_o       = 1'b0;
    bus.ar_valid_o    = 1'b0;
    bus.ar_addr_o     = '0;
    bus.r_ready_o     = 1'b0;
    w_accept          = 1'b0;
    w_cap_hit         = 1'b0;
    w_cap_w0          = 1'b0;
    w_cap_w1          = 1'b0;
    w_set_fault       = 1'b0;
    w_mark_flush      = 1'b0;
    w_install         = 1'b0;
    w_install_tag     = '0;

    case (r_state)
      IFR_ST_IDLE: begin
        if (bus.fetch_req_i && !bus.flush_i) begin
          w_accept = 1'b1;
          if (w_buf_hit) begin
            w_cap_hit = 1'b1;
            w_next    = w_hit_needs_w1 ? IFR_ST_REQ1 : IFR_ST_RESP;
          end else begin
            w_next = IFR_ST_REQ0;
          end
        end
      end

      IFR_ST_REQ0: begin
        bus.ar_valid_o = 1'b1;
        bus.ar_addr_o  = w_cur_w0;
        w_mark_flush   = bus.flush_i;
        if (bus.ar_ready_i) begin
          w_next = (bus.flush_i || r_flushed) ? IFR_ST_DRAIN : IFR_ST_WAIT0;
        end
      end

      IFR_ST_WAIT0: begin
        bus.r_ready_o = 1'b1;
        if (bus.flush_i) begin
          w_next = bus.r_valid_i ? IFR_ST_IDLE : IFR_ST_DRAIN;
        end else if (bus.r_valid_i) begin
          if (bus.r_resp_i != AXI_RESP_OKAY) begin
            w_set_fault = 1'b1;
            w_next      = IFR_ST_RESP;
          end else begin
            w_cap_w0      = 1'b1;
            w_install     = 1'b1;
            w_install_tag = w_cur_w0[ADDR_W-1:2];
            if (r_pc[1] && ifr_is_full_width(bus.r_data_i[31:16])) w_next = IFR_ST_REQ1;
            else                                                  w_next = IFR_ST_RESP;
          end
        end
      end

      IFR_ST_REQ1: begin
        bus.ar_valid_o = 1'b1;
        bus.ar_addr_o  = w_cur_w1;
        w_mark_flush   = bus.flush_i;
        if (bus.ar_ready_i) begin
          w_next = (bus.flush_i || r_flushed) ? IFR_ST_DRAIN : IFR_ST_WAIT1;
        end
      end

      IFR_ST_WAIT1: begin
        bus.r_ready_o = 1'b1;
        if (bus.flush_i) begin
          w_next = bus.r_valid_i ? IFR_ST_IDLE : IFR_ST_DRAIN;
        end else if (bus.r_valid_i) begin
          if (bus.r_resp_i != AXI_RESP_OKAY) begin
            w_set_fault = 1'b1;
          end else begin
            w_cap_w1      = 1'b1;
            w_install     = 1'b1;
            w_install_tag = w_cur_w1[ADDR_W-1:2];
          end
          w_next = IFR_ST_RESP;
        end
      end

      IFR_ST_RESP: begin
        if (!bus.flush_i) begin
          bus.rdata_valid_o = 1'b1;
          bus.fault_o       = r_fault;
          bus.rdata_o       = r_fault ? 32'h0 : ifr_format(r_pc[1], w_straddle, r_w0, r_w1lo);
        end
        w_next = IFR_ST_IDLE;
      end

      IFR_ST_DRAIN: begin
        bus.r_ready_o = 1'b1;
        if (bus.r_valid_i) w_next = IFR_ST_IDLE;
      end

      default: w_next = IFR_ST_IDLE;
    endcase
  end

  // Request datapath: latched PC, first word, low half of the second word,
  // the fault flag and the pending-flush flag. All are reloaded or cleared
  // when a new request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_w0      <= '0;
      r_w1lo    <= '0;
      r_fault   <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc      <= bus.fetch_addr_i[ADDR_W-1:1];
        r_fault   <= 1'b0;
        r_flushed <= 1'b0;
      end
      if (w_cap_hit)    r_w0      <= w_buf_data;
      if (w_cap_w0)     r_w0      <= bus.r_data_i;
      if (w_cap_w1)     r_w1lo    <= bus.r_data_i[15:0];
      if (w_set_fault)  r_fault   <= 1'b1;
      if (w_mark_flush) r_flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// ----------------------------------------------------------------------------
// tb_ifetch_responder
// Directed bench for ifetch_responder. A behavioural AXI-lite memory answers
// every read after rDelay idle cycles and returns an error response for
// errAddr. The main initial block walks through aligned/RVC/straddling
// fetches, buffer hits, flush, bus errors, fence, address wrap and reset.
// ----------------------------------------------------------------------------
module tb_ifetch_responder;

  logic clk;
  logic rst;

  ifetch_responder_if #(.ADDR_W(32)) ifc ();

  ifetch_responder #(
    .ADDR_W (32),
    .BUF_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Memory model state
  int          rDelay  = 0;
  logic [31:0] errAddr = 32'h8000_0020;
  logic [31:0] arLog[$];
  int          arCount = 0;
  bit          pend    = 1'b0;
  int          pendCnt = 0;
  logic [31:0] pendAddr;
  bit          rTaken  = 1'b0;

  // Results of the last applyStimulus call
  bit          gotValid;
  logic [31:0] gotData;
  bit          gotFault;
  int          gotLat;
  bit          gotExtra;
  int          gotArs;
  int          arBefore;

  bit          seenFlag;
  int          sz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents used by the directed steps.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h8000_0000: memWord = 32'h4501_0513;
      32'h8000_0004: memWord = 32'h0297_1111;
      32'h8000_0008: memWord = 32'hABCD_0001;
      32'hFFFF_FFFC: memWord = 32'h0003_2222;
      32'h0000_0000: memWord = 32'h5555_7777;
      default:       memWord = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // AXI-lite memory: ar_ready held high; each accepted address produces one
  // beat after rDelay cycles, held until r_ready is seen.
  initial begin
    ifc.ar_ready_i = 1'b1;
    ifc.r_valid_i  = 1'b0;
    ifc.r_data_i   = 32'h0;
    ifc.r_resp_i   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend          = 1'b0;
        rTaken        = 1'b0;
        ifc.r_valid_i = 1'b0;
        ifc.r_data_i  = 32'h0;
        ifc.r_resp_i  = 2'b00;
      end else begin
        if (rTaken) begin
          ifc.r_valid_i = 1'b0;
          ifc.r_data_i  = 32'h0;
          ifc.r_resp_i  = 2'b00;
          pend          = 1'b0;
          rTaken        = 1'b0;
        end
        if (pend && !ifc.r_valid_i) begin
          if (pendCnt == 0) begin
            ifc.r_valid_i = 1'b1;
            ifc.r_data_i  = memWord(pendAddr);
            ifc.r_resp_i  = (pendAddr == errAddr) ? 2'b10 : 2'b00;
          end else begin
            pendCnt--;
          end
        end
        if (ifc.ar_valid_o && ifc.ar_ready_i) begin
          arLog.push_back(ifc.ar_addr_o);
          arCount++;
          pend     = 1'b1;
          pendCnt  = rDelay;
          pendAddr = ifc.ar_addr_o;
        end
        if (ifc.r_valid_i && ifc.r_ready_o) rTaken = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one fetch, wait (bounded) for the valid pulse, drop the request
  // and sample the following cycle to confirm the pulse lasted one cycle.
  task automatic applyStimulus(input logic [31:0] addr);
    arBefore         = arCount;
    gotValid         = 1'b0;
    gotLat           = 0;
    gotData          = 32'h0;
    gotFault         = 1'b0;
    ifc.fetch_addr_i = addr;
    ifc.fetch_req_i  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ifc.rdata_valid_o) begin
        gotValid = 1'b1;
        gotLat   = n;
        gotData  = ifc.rdata_o;
        gotFault = ifc.fault_o;
        break;
      end
    end
    ifc.fetch_req_i = 1'b0;
    @(negedge clk);
    gotExtra = ifc.rdata_valid_o;
    gotArs   = arCount - arBefore;
  endtask

  task automatic waitReady();
    seenFlag = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifc.r_ready_o) begin
        seenFlag = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    ifc.fetch_req_i  = 1'b0;
    ifc.fetch_addr_i = 32'h0;
    ifc.flush_i      = 1'b0;
    ifc.fence_i_i    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_valid",   ifc.rdata_valid_o, 32'd0);
    checkOutput("rst_rdata",   ifc.rdata_o,       32'd0);
    checkOutput("rst_fault",   ifc.fault_o,       32'd0);
    checkOutput("rst_arvalid", ifc.ar_valid_o,    32'd0);
    checkOutput("rst_rready",  ifc.r_ready_o,     32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Aligned miss
    applyStimulus(32'h8000_0000);
    checkOutput("t1_valid", gotValid, 32'd1);
    checkOutput("t1_rdata", gotData,  32'h4501_0513);
    checkOutput("t1_fault", gotFault, 32'd0);
    checkOutput("t1_ars",   gotArs,   32'd1);
    checkOutput("t1_araddr", arLog[arLog.size()-1], 32'h8000_0000);
    checkOutput("t1_pulse", gotExtra, 32'd0);

    // Buffer hit, compressed instruction in the upper half
    applyStimulus(32'h8000_0002);
    checkOutput("t2_rdata", gotData, 32'h0000_4501);
    checkOutput("t2_ars",   gotArs,  32'd0);
    checkOutput("t2_lat",   gotLat,  32'd1);
    checkOutput("t2_pulse", gotExtra, 32'd0);

    // Straddle with both words missing
    applyStimulus(32'h8000_0006);
    sz = arLog.size();
    checkOutput("t3_rdata", gotData, 32'h0001_0297);
    checkOutput("t3_ars",   gotArs,  32'd2);
    checkOutput("t3_ar0",   arLog[sz-2], 32'h8000_0004);
    checkOutput("t3_ar1",   arLog[sz-1], 32'h8000_0008);

    // Flush while waiting for a slow beat
    rDelay           = 3;
    arBefore         = arCount;
    ifc.fetch_addr_i = 32'h8000_0010;
    ifc.fetch_req_i  = 1'b1;
    waitReady();
    checkOutput("t4_in_wait0", seenFlag, 32'd1);
    ifc.flush_i     = 1'b1;
    ifc.fetch_req_i = 1'b0;
    @(negedge clk);
    ifc.flush_i = 1'b0;
    checkOutput("t4_drain_ready", ifc.r_ready_o, 32'd1);
    seenFlag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.rdata_valid_o) seenFlag = 1'b1;
    end
    checkOutput("t4_no_valid", seenFlag, 32'd0);
    checkOutput("t4_ars", arCount - arBefore, 32'd1);
    checkOutput("t4_idle_rready", ifc.r_ready_o, 32'd0);
    rDelay = 0;
    applyStimulus(32'h8000_0008);
    checkOutput("t4_hit_rdata", gotData, 32'hABCD_0001);
    checkOutput("t4_hit_ars",   gotArs,  32'd0);
    applyStimulus(32'h8000_000A);
    checkOutput("t4_rvc_rdata", gotData, 32'h0000_ABCD);
    applyStimulus(32'h8000_0010);
    checkOutput("t4_miss_rdata", gotData, 32'h9357_9BCF);
    checkOutput("t4_miss_ars",   gotArs,  32'd1);

    // Straddle where the first word hits and only the second is fetched
    applyStimulus(32'h8000_0004);
    checkOutput("t4b_rdata0", gotData, 32'h0297_1111);
    applyStimulus(32'h8000_0006);
    checkOutput("t4b_rdata", gotData, 32'h0001_0297);
    checkOutput("t4b_ars",   gotArs,  32'd1);
    checkOutput("t4b_araddr", arLog[arLog.size()-1], 32'h8000_0008);

    // Bus error on the first beat, twice
    applyStimulus(32'h8000_0020);
    checkOutput("t5_valid", gotValid, 32'd1);
    checkOutput("t5_fault", gotFault, 32'd1);
    checkOutput("t5_rdata", gotData,  32'h0);
    applyStimulus(32'h8000_0020);
    checkOutput("t5_rep_ars",   gotArs,   32'd1);
    checkOutput("t5_rep_fault", gotFault, 32'd1);

    // Fence invalidates the buffer
    applyStimulus(32'h8000_0000);
    checkOutput("t6_fill_ars", gotArs, 32'd1);
    applyStimulus(32'h8000_0000);
    checkOutput("t6_hit_ars", gotArs, 32'd0);
    ifc.fence_i_i = 1'b1;
    @(negedge clk);
    ifc.fence_i_i = 1'b0;
    applyStimulus(32'h8000_0000);
    checkOutput("t6_fence_ars",   gotArs,  32'd1);
    checkOutput("t6_fence_rdata", gotData, 32'h4501_0513);

    // Straddle at the top of the address space wraps to word 0
    applyStimulus(32'hFFFF_FFFE);
    checkOutput("wrap_ars",    gotArs,  32'd2);
    checkOutput("wrap_araddr", arLog[arLog.size()-1], 32'h0000_0000);
    checkOutput("wrap_rdata",  gotData, 32'h7777_0003);

    // Reset in the middle of WAIT0
    rDelay           = 5;
    ifc.fetch_addr_i = 32'h8000_0030;
    ifc.fetch_req_i  = 1'b1;
    waitReady();
    checkOutput("rst2_in_wait0", seenFlag, 32'd1);
    ifc.fetch_req_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst2_rready",  ifc.r_ready_o,     32'd0);
    checkOutput("rst2_arvalid", ifc.ar_valid_o,    32'd0);
    checkOutput("rst2_valid",   ifc.rdata_valid_o, 32'd0);
    checkOutput("rst2_rdata",   ifc.rdata_o,       32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    rDelay = 0;
    @(negedge clk);
    applyStimulus(32'h0000_0000);
    checkOutput("rst2_miss_ars",   gotArs,  32'd1);
    checkOutput("rst2_miss_rdata", gotData, 32'h5555_7777);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
